rgb_fade_ctrl: RTL

RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

---
 rtl/rgb_fade_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rgb_fade_ctrl.sv
// RGB fade controller: accepts a target colour, then walks each duty channel
// one LSB per divided step toward it, with abort and a one-cycle done pulse.
module rgb_fade_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tgt_valid,
   output logic                 tgt_ready,
   input  logic [WIDTH-1:0]     tgt_r,
   input  logic [WIDTH-1:0]     tgt_g,
   input  logic [WIDTH-1:0]     tgt_b,
   input  logic [DIV_WIDTH-1:0] step_div,
   input  logic                 abort,
   output logic [WIDTH-1:0]     duty_r,
   output logic [WIDTH-1:0]     duty_g,
   output logic [WIDTH-1:0]     duty_b,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, FADE, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
   logic [WIDTH-1:0]     tgt_r_q, tgt_r_d, tgt_g_q, tgt_g_d, tgt_b_q, tgt_b_d;
   logic [DIV_WIDTH-1:0] div_q, div_d, pre_q, pre_d;
   logic [WIDTH-1:0]     nxt_r, nxt_g, nxt_b;
   logic                 step;

   // Moving strictly toward the target can never wrap past either rail.
   function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
      if (cur < tgt)      return cur + WIDTH'(1);
      else if (cur > tgt) return cur - WIDTH'(1);
      else                return cur;
   endfunction

   assign nxt_r = step_toward(duty_r_q, tgt_r_q);
   assign nxt_g = step_toward(duty_g_q, tgt_g_q);
   assign nxt_b = step_toward(duty_b_q, tgt_b_q);
   assign step  = (pre_q == div_q - DIV_WIDTH'(1));

   always_comb begin
      state_d  = state_q;
      duty_r_d = duty_r_q;
      duty_g_d = duty_g_q;
      duty_b_d = duty_b_q;
      tgt_r_d  = tgt_r_q;
      tgt_g_d  = tgt_g_q;
      tgt_b_d  = tgt_b_q;
      div_d    = div_q;
      pre_d    = pre_q;
      case (state_q)
         IDLE: begin
            if (tgt_valid) begin
               tgt_r_d = tgt_r;
               tgt_g_d = tgt_g;
               tgt_b_d = tgt_b;
               div_d   = (step_div == '0) ? DIV_WIDTH'(1) : step_div;
               pre_d   = '0;
               if (tgt_r == duty_r_q && tgt_g == duty_g_q && tgt_b == duty_b_q)
                  state_d = DONE;
               else
                  state_d = FADE;
            end
         end
         FADE: begin
            // Abort wins over a coinciding step so the duties freeze as seen.
            if (abort) begin
               state_d = IDLE;
            end else if (step) begin
               pre_d    = '0;
               duty_r_d = nxt_r;
               duty_g_d = nxt_g;
               duty_b_d = nxt_b;
               if (nxt_r == tgt_r_q && nxt_g == tgt_g_q && nxt_b == tgt_b_q)
                  state_d = DONE;
            end else begin
               pre_d = pre_q + DIV_WIDTH'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         duty_r_q <= '0;
         duty_g_q <= '0;
         duty_b_q <= '0;
         tgt_r_q  <= '0;
         tgt_g_q  <= '0;
         tgt_b_q  <= '0;
         div_q    <= '0;
         pre_q    <= '0;
      end else begin
         state_q  <= state_d;
         duty_r_q <= duty_r_d;
         duty_g_q <= duty_g_d;
         duty_b_q <= duty_b_d;
         tgt_r_q  <= tgt_r_d;
         tgt_g_q  <= tgt_g_d;
         tgt_b_q  <= tgt_b_d;
         div_q    <= div_d;
         pre_q    <= pre_d;
      end
   end

   // Status decodes straight from state so reset reaches them without a clock.
   assign tgt_ready = (state_q == IDLE);
   assign busy      = (state_q == FADE);
   assign done      = (state_q == DONE);
   assign duty_r    = duty_r_q;
   assign duty_g    = duty_g_q;
   assign duty_b    = duty_b_q;

endmodule
